// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX stage -> ALU handshake bundle, including both writeback forwarding buses.
// The stage takes the slave modport; decode/consumer/writeback logic takes the master side.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_alu_control;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [4:0]      in_rd_addr;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic            in_reg_write;
  logic            flush;
  logic            fwd1_we;
  logic [4:0]      fwd1_rd;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_we;
  logic [4:0]      fwd2_rd;
  logic [XLEN-1:0] fwd2_data;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      ALU_Control;
  logic [XLEN-1:0] operand_A;
  logic [XLEN-1:0] operand_B;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic [15:0]     stall_count;

  modport master (
    output in_valid, in_alu_control, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_imm, in_use_imm, in_reg_write, flush,
           fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data, out_ready,
    input  in_ready, out_valid, ALU_Control, operand_A, operand_B, out_rd, out_reg_write,
           stall_count
  );

  modport slave (
    input  in_valid, in_alu_control, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_imm, in_use_imm, in_reg_write, flush,
           fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data, out_ready,
    output in_ready, out_valid, ALU_Control, operand_A, operand_B, out_rd, out_reg_write,
           stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with full-throughput handshake, two-level operand
// forwarding (EX/MEM over MEM/WB), forward capture while stalled and a saturating stall counter.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);
  localparam int NUM_SRC = 2;

  logic                            vld_q;
  logic [5:0]                      alu_q;
  logic [NUM_SRC-1:0][XLEN-1:0]    rs_q;
  logic [NUM_SRC-1:0][4:0]         addr_q;
  logic [4:0]                      rd_q;
  logic [XLEN-1:0]                 imm_q;
  logic                            use_imm_q;
  logic                            reg_write_q;
  logic [15:0]                     stall_q;

  logic [NUM_SRC-1:0][XLEN-1:0]    rs_in;
  logic [NUM_SRC-1:0][4:0]         addr_in;
  logic [NUM_SRC-1:0][XLEN-1:0]    rs_fwd;
  logic                            in_ready;
  logic                            capture;
  logic                            xfer;
  logic                            hold;

  assign rs_in   = {bus.in_rs2_data, bus.in_rs1_data};
  assign addr_in = {bus.in_rs2_addr, bus.in_rs1_addr};

  assign in_ready = (!vld_q || bus.out_ready) && !bus.flush;
  assign capture  = bus.in_valid && in_ready;
  assign xfer     = vld_q && bus.out_ready;
  assign hold     = vld_q && !bus.out_ready;

  // EX/MEM beats MEM/WB beats the registered value; x0 is never a forwarding target.
  always_comb begin
    rs_fwd = rs_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (addr_q[i] != 5'd0) begin
        if (bus.fwd1_we && (bus.fwd1_rd == addr_q[i]))
          rs_fwd[i] = bus.fwd1_data;
        else if (bus.fwd2_we && (bus.fwd2_rd == addr_q[i]))
          rs_fwd[i] = bus.fwd2_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      alu_q       <= 6'd0;
      rs_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 5'd0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      stall_q     <= 16'd0;
    end else begin
      if (bus.flush) begin
        vld_q <= 1'b0;
      end else if (capture) begin
        vld_q       <= 1'b1;
        alu_q       <= bus.in_alu_control;
        rs_q        <= rs_in;
        addr_q      <= addr_in;
        rd_q        <= bus.in_rd_addr;
        imm_q       <= bus.in_imm;
        use_imm_q   <= bus.in_use_imm;
        reg_write_q <= bus.in_reg_write;
      end else if (xfer) begin
        vld_q <= 1'b0;
      end else if (hold) begin
        // Latch forwarded values so they survive once the writeback bus moves on.
        rs_q <= rs_fwd;
      end
      if (hold && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = vld_q;
  assign bus.ALU_Control   = alu_q;
  assign bus.operand_A     = rs_fwd[0];
  assign bus.operand_B     = use_imm_q ? imm_q : rs_fwd[1];
  assign bus.out_rd        = rd_q;
  assign bus.out_reg_write = vld_q && reg_write_q;
  assign bus.stall_count   = stall_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal cases plus randomized traffic checked every cycle
// against a behavioural one-slot model.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();
  id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Model: the one instruction the stage is holding, if any.
  logic            m_v;
  logic [5:0]      m_alu;
  logic [XLEN-1:0] m_rs1, m_rs2, m_imm;
  logic [4:0]      m_a1, m_a2, m_rd;
  logic            m_ui, m_rw;
  int              m_stall;

  logic [5:0] ops [5] = '{6'b000000, 6'b001000, 6'b000010, 6'b000100, 6'b000111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] r);
    if (a == 5'd0) return r;
    if (bus.fwd1_we && bus.fwd1_rd == a) return bus.fwd1_data;
    if (bus.fwd2_we && bus.fwd2_rd == a) return bus.fwd2_data;
    return r;
  endfunction

  task automatic model_reset();
    m_v = 0; m_alu = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    m_a1 = 0; m_a2 = 0; m_rd = 0; m_ui = 0; m_rw = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    logic rdy;
    rdy = (!m_v || bus.out_ready) && !bus.flush;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, m_v);
    chk("out_reg_write", bus.out_reg_write, m_v && m_rw);
    chk("stall_count", bus.stall_count, m_stall);
    if (m_v) begin
      chk("alu_control", bus.ALU_Control, m_alu);
      chk("operand_A", bus.operand_A, fwd(m_a1, m_rs1));
      chk("operand_B", bus.operand_B, m_ui ? m_imm : fwd(m_a2, m_rs2));
      chk("out_rd", bus.out_rd, m_rd);
    end
  endtask

  task automatic model_edge();
    logic rdy;
    rdy = (!m_v || bus.out_ready) && !bus.flush;
    if (m_v && !bus.out_ready && m_stall < 65535) m_stall++;
    if (bus.flush) m_v = 0;
    else if (bus.in_valid && rdy) begin
      m_v = 1; m_alu = bus.in_alu_control;
      m_rs1 = bus.in_rs1_data; m_rs2 = bus.in_rs2_data;
      m_a1 = bus.in_rs1_addr; m_a2 = bus.in_rs2_addr; m_rd = bus.in_rd_addr;
      m_imm = bus.in_imm; m_ui = bus.in_use_imm; m_rw = bus.in_reg_write;
    end else if (m_v && bus.out_ready) m_v = 0;
    else if (m_v) begin
      m_rs1 = fwd(m_a1, m_rs1);
      m_rs2 = fwd(m_a2, m_rs2);
    end
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_alu_control = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
    bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0; bus.in_imm = 0;
    bus.in_use_imm = 0; bus.in_reg_write = 0; bus.flush = 0;
    bus.fwd1_we = 0; bus.fwd1_rd = 0; bus.fwd1_data = 0;
    bus.fwd2_we = 0; bus.fwd2_rd = 0; bus.fwd2_data = 0;
    bus.out_ready = 0;
  endtask

  task automatic load(input logic [4:0] a1, input logic [XLEN-1:0] d1,
                      input logic [4:0] a2, input logic [XLEN-1:0] d2, input logic [4:0] rd);
    bus.in_valid = 1; bus.in_alu_control = 6'b000000;
    bus.in_rs1_addr = a1; bus.in_rs1_data = d1;
    bus.in_rs2_addr = a2; bus.in_rs2_data = d2;
    bus.in_rd_addr = rd; bus.in_reg_write = 1; bus.in_use_imm = 0; bus.in_imm = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_reg_write", bus.out_reg_write, 0);
    chk("rst alu_control", bus.ALU_Control, 0);
    chk("rst operand_A", bus.operand_A, 0);
    chk("rst operand_B", bus.operand_B, 0);
    chk("rst out_rd", bus.out_rd, 0);
    chk("rst stall_count", bus.stall_count, 0);
    @(negedge clk);
    rst_n = 1;
    settle();
    chk("in_ready after reset", bus.in_ready, 1);

    // Plain capture, then transfer out.
    load(5'd1, 32'd5, 5'd2, 32'd7, 5'd9);
    bus.out_ready = 1;
    settle(); tick();
    idle_inputs(); bus.out_ready = 1;
    settle();
    chk("cap out_valid", bus.out_valid, 1);
    chk("cap operand_A", bus.operand_A, 32'd5);
    chk("cap operand_B", bus.operand_B, 32'd7);
    tick();
    settle();
    chk("xfer out_valid", bus.out_valid, 0);

    // Forward priority and x0 guard on a held entry.
    load(5'd3, 32'h11, 5'd0, 32'h0, 5'd4);
    bus.out_ready = 1;
    settle(); tick();
    idle_inputs();
    bus.fwd1_we = 1; bus.fwd1_rd = 3; bus.fwd1_data = 32'hAA;
    bus.fwd2_we = 1; bus.fwd2_rd = 3; bus.fwd2_data = 32'hBB;
    settle();
    chk("fwd1 priority", bus.operand_A, 32'hAA);
    bus.fwd1_we = 0;
    settle();
    chk("fwd2 fallback", bus.operand_A, 32'hBB);
    bus.fwd1_we = 1; bus.fwd1_rd = 0; bus.fwd1_data = 32'hFF; bus.fwd2_we = 0;
    settle();
    chk("x0 guard", bus.operand_B, 32'h0);
    tick();
    idle_inputs(); bus.out_ready = 1;
    settle(); tick();

    // Flush beats a simultaneous capture.
    load(5'd6, 32'h66, 5'd7, 32'h77, 5'd8);
    settle(); tick();
    load(5'd10, 32'h1010, 5'd11, 32'h1111, 5'd12);
    bus.flush = 1;
    settle();
    chk("flush in_ready", bus.in_ready, 0);
    tick();
    idle_inputs();
    settle();
    chk("flush out_valid", bus.out_valid, 0);
    chk("flush out_reg_write", bus.out_reg_write, 0);
    tick();

    // Asynchronous reset in the middle of a held instruction.
    load(5'd13, 32'h13, 5'd14, 32'h14, 5'd15);
    settle(); tick();
    idle_inputs();
    settle();
    chk("pre-reset out_valid", bus.out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async out_valid", bus.out_valid, 0);
    chk("async stall_count", bus.stall_count, 0);
    chk("async out_reg_write", bus.out_reg_write, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    settle();

    // Forward seen in the first stalled cycle only must persist.
    load(5'd5, 32'h55, 5'd4, 32'h99, 5'd3);
    bus.out_ready = 1;
    settle(); tick();
    load(5'd20, 32'hDEAD, 5'd21, 32'hBEEF, 5'd22);
    bus.out_ready = 0;
    bus.fwd1_we = 1; bus.fwd1_rd = 4; bus.fwd1_data = 32'h12;
    settle();
    chk("stall1 in_ready", bus.in_ready, 0);
    tick();
    bus.fwd1_we = 0; bus.fwd1_rd = 0; bus.fwd1_data = 0;
    settle(); tick();
    settle(); tick();
    settle();
    chk("persist operand_B", bus.operand_B, 32'h12);
    chk("persist stall_count", bus.stall_count, 3);
    chk("persist in_ready", bus.in_ready, 0);
    chk("persist operand_A", bus.operand_A, 32'h55);
    idle_inputs(); bus.out_ready = 1;
    settle(); tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid       = ($urandom_range(0, 9) < 7);
      bus.in_alu_control = ops[$urandom_range(0, 4)];
      bus.in_rs1_data    = $urandom;
      bus.in_rs2_data    = $urandom;
      bus.in_rs1_addr    = 5'($urandom_range(0, 7));
      bus.in_rs2_addr    = 5'($urandom_range(0, 7));
      bus.in_rd_addr     = 5'($urandom_range(0, 31));
      bus.in_imm         = $urandom;
      bus.in_use_imm     = $urandom_range(0, 1);
      bus.in_reg_write   = $urandom_range(0, 1);
      bus.flush          = ($urandom_range(0, 19) == 0);
      bus.out_ready      = ($urandom_range(0, 9) < 6);
      bus.fwd1_we        = $urandom_range(0, 1);
      bus.fwd1_rd        = 5'($urandom_range(0, 7));
      bus.fwd1_data      = $urandom;
      bus.fwd2_we        = $urandom_range(0, 1);
      bus.fwd2_rd        = 5'($urandom_range(0, 7));
      bus.fwd2_data      = $urandom;
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
